// File: rtl/timer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL bit layout, mtime type.
package timer_pkg;

  // Word offsets, decoded from req_addr[4:2]
  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CTRL        = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_DIV_LSB = 16;

  typedef logic [63:0] mtime_t;

endpackage

// File: rtl/machine_timer_if.sv
// Word-addressed request/response bus between the core data port and the timer.
interface machine_timer_if;

  logic        req_valid;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/timer_prescaler.sv
// Programmable divider: counts 0..div while enabled and emits a one-cycle tick on div.
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  // Tick is combinational so mtime advances on the edge that ends the div-th count.
  assign tick = en && (cnt == div);

  // Phase counter: held at 0 when disabled or cleared by a CTRL write, wraps after div.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || !en || (cnt == div)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a word bus, level interrupt while mtime >= mtimecmp.
module machine_timer
  import timer_pkg::*;
#(
  parameter int          PRESC_W = 16,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  machine_timer_if.slave   bus,
  output logic             intr_timer
);

  mtime_t             mtime;
  mtime_t             mtimecmp;
  mtime_t             mtime_nxt;
  mtime_t             mtimecmp_nxt;
  logic               en;
  logic [PRESC_W-1:0] div;
  logic [31:0]        hi_snap;
  logic [31:0]        ctrl_word;
  logic [31:0]        rdata_nxt;
  logic [2:0]         sel;
  logic               wr;
  logic               rd;
  logic               tick;
  logic               unused_addr_bits;

  // Byte-lane bits are ignored: every access is a full word.
  assign unused_addr_bits = ^bus.req_addr[1:0];

  assign sel = bus.req_addr[4:2];
  assign wr  = bus.req_valid && bus.req_write;
  assign rd  = bus.req_valid && !bus.req_write;

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .div   (div),
    .clr   (wr && (sel == CTRL)),
    .tick  (tick)
  );

  // CTRL read image: EN and DIV fields, all other bits zero.
  always_comb begin
    ctrl_word                            = '0;
    ctrl_word[CTRL_EN]                   = en;
    ctrl_word[CTRL_DIV_LSB +: PRESC_W]   = div;
  end

  // Post-edge mtime/mtimecmp: a bus write to a half wins over the tick and suppresses the carry.
  always_comb begin
    mtime_nxt    = mtime;
    mtimecmp_nxt = mtimecmp;
    if (wr && (sel == MTIME_LO)) begin
      mtime_nxt[31:0] = bus.req_wdata;
    end else if (wr && (sel == MTIME_HI)) begin
      mtime_nxt[63:32] = bus.req_wdata;
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
    if (wr && (sel == MTIMECMP_LO)) begin
      mtimecmp_nxt[31:0] = bus.req_wdata;
    end
    if (wr && (sel == MTIMECMP_HI)) begin
      mtimecmp_nxt[63:32] = bus.req_wdata;
    end
  end

  // Read mux on pre-edge state; MTIME_HI returns the snapshot taken by the last MTIME_LO read.
  always_comb begin
    rdata_nxt = '0;
    if (rd) begin
      case (sel)
        MTIME_LO:    rdata_nxt = mtime[31:0];
        MTIME_HI:    rdata_nxt = hi_snap;
        MTIMECMP_LO: rdata_nxt = mtimecmp[31:0];
        MTIMECMP_HI: rdata_nxt = mtimecmp[63:32];
        CTRL:        rdata_nxt = ctrl_word;
        default:     rdata_nxt = '0;
      endcase
    end
  end

  // Timer state, CTRL fields and the high-word snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= CMP_RST;
      en       <= 1'b0;
      div      <= '0;
      hi_snap  <= '0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      if (wr && (sel == CTRL)) begin
        en  <= bus.req_wdata[CTRL_EN];
        div <= bus.req_wdata[CTRL_DIV_LSB +: PRESC_W];
      end
      if (rd && (sel == MTIME_LO)) begin
        hi_snap <= mtime[63:32];
      end
    end
  end

  // Registered response and interrupt; the compare uses the values being written this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      intr_timer    <= 1'b0;
    end else begin
      bus.rsp_valid <= bus.req_valid;
      bus.rsp_rdata <= rdata_nxt;
      intr_timer    <= (mtime_nxt >= mtimecmp_nxt);
    end
  end

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer with a cycle model of the register behaviour.
module tb_machine_timer;
  import timer_pkg::*;

  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic intr_timer;

  machine_timer_if bus();

  machine_timer #(
    .PRESC_W (16),
    .CMP_RST (CMP_RST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .intr_timer (intr_timer)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model: time advances once every (div+1) cycles counted from the last CTRL write.
  logic [63:0] m_time, m_cmp;
  logic        m_en;
  logic [15:0] m_div;
  int unsigned m_since;
  logic [31:0] m_snap;
  logic        e_vld;
  logic [31:0] e_rdata;
  logic        e_intr;
  logic        m_tick, m_time_wr, m_ctrl_wr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_time = 64'd0; m_cmp = CMP_RST; m_en = 1'b0; m_div = 16'd0;
      m_since = 0; m_snap = 32'd0; e_vld = 1'b0; e_rdata = 32'd0; e_intr = 1'b0;
    end else begin
      m_tick    = m_en && ((m_since % (int'(m_div) + 1)) == int'(m_div));
      m_time_wr = 1'b0;
      m_ctrl_wr = 1'b0;
      e_vld     = bus.req_valid;
      e_rdata   = 32'd0;
      if (bus.req_valid && !bus.req_write) begin
        case (bus.req_addr[4:2])
          3'd0: begin e_rdata = m_time[31:0]; m_snap = m_time[63:32]; end
          3'd1: e_rdata = m_snap;
          3'd2: e_rdata = m_cmp[31:0];
          3'd3: e_rdata = m_cmp[63:32];
          3'd4: e_rdata = {m_div, 15'd0, m_en};
          default: e_rdata = 32'd0;
        endcase
      end
      if (bus.req_valid && bus.req_write) begin
        case (bus.req_addr[4:2])
          3'd0: begin m_time[31:0]  = bus.req_wdata; m_time_wr = 1'b1; end
          3'd1: begin m_time[63:32] = bus.req_wdata; m_time_wr = 1'b1; end
          3'd2: m_cmp[31:0]  = bus.req_wdata;
          3'd3: m_cmp[63:32] = bus.req_wdata;
          3'd4: begin m_en = bus.req_wdata[0]; m_div = bus.req_wdata[31:16]; m_ctrl_wr = 1'b1; end
          default: ;
        endcase
      end
      if (m_tick && !m_time_wr) m_time = m_time + 64'd1;
      if (m_ctrl_wr || !m_en) m_since = 0;
      else m_since = m_since + 1;
      e_intr = (m_time >= m_cmp);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, e_vld});
    if (e_vld) check("cyc_rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, e_rdata});
    check("cyc_intr", {63'd0, intr_timer}, {63'd0, e_intr});
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_wdata = d;
    @(negedge clk);
    check("wr_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_wdata = 32'd0;
    @(negedge clk);
    d = bus.rsp_rdata;
    check("rd_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] d, d2;

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 5'd0; bus.req_wdata = 32'd0;
    idle(3);
    reset = 1'b0;
    check("rst_intr", {63'd0, intr_timer}, 64'd0);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);

    // 1: reset values, back-to-back reads
    rd(5'h00, d); check("t1_mtime_lo", {32'd0, d}, 64'h0);
    rd(5'h04, d); check("t1_mtime_hi", {32'd0, d}, 64'h0);
    rd(5'h08, d); check("t1_cmp_lo", {32'd0, d}, 64'hFFFF_FFFF);
    rd(5'h0C, d); check("t1_cmp_hi", {32'd0, d}, 64'hFFFF_FFFF);
    rd(5'h10, d); check("t1_ctrl", {32'd0, d}, 64'h0);

    // 2: DIV=3 -> one increment per 4 cycles
    wr(5'h10, 32'h0003_0001);
    idle(40);
    rd(5'h00, d); check("t2_mtime_lo_40cyc", {32'd0, d}, 64'd10);
    rd(5'h10, d); check("t2_ctrl_readback", {32'd0, d}, 64'h0003_0001);
    wr(5'h10, 32'h0);

    // 3: compare match and clear
    wr(5'h00, 32'h0);
    wr(5'h04, 32'h0);
    wr(5'h0C, 32'h0);
    wr(5'h08, 32'd5);
    check("t3_intr_before_en", {63'd0, intr_timer}, 64'd0);
    wr(5'h10, 32'h0000_0001);
    idle(4);
    check("t3_intr_at_4", {63'd0, intr_timer}, 64'd0);
    idle(1);
    check("t3_intr_at_5", {63'd0, intr_timer}, 64'd1);
    wr(5'h08, 32'd100);
    check("t3_intr_cleared", {63'd0, intr_timer}, 64'd0);
    wr(5'h10, 32'h0);

    // 4: carry into the high word, and snapshot consistency across the carry
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h04, 32'h0);
    wr(5'h10, 32'h0000_0001);
    idle(1);
    wr(5'h10, 32'h0);
    rd(5'h00, d);  check("t4_lo_after_carry", {32'd0, d}, 64'h0);
    rd(5'h04, d2); check("t4_hi_after_carry", {32'd0, d2}, 64'h1);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'h0);
    wr(5'h10, 32'h0000_0001);
    rd(5'h00, d);  check("t4_snap_lo", {32'd0, d}, 64'hFFFF_FFFF);
    rd(5'h04, d2); check("t4_snap_hi", {32'd0, d2}, 64'h0);
    rd(5'h04, d2); check("t4_snap_hi_sticky", {32'd0, d2}, 64'h0);
    wr(5'h10, 32'h0);

    // 5: write beats the simultaneous tick
    wr(5'h10, 32'h0000_0001);
    wr(5'h00, 32'h0000_1234);
    rd(5'h00, d); check("t5_write_wins", {32'd0, d}, 64'h1234);
    wr(5'h10, 32'h0);

    // unmapped offsets
    wr(5'h1C, 32'hDEAD_BEEF);
    rd(5'h1C, d); check("unmapped_1c", {32'd0, d}, 64'h0);
    rd(5'h14, d); check("unmapped_14", {32'd0, d}, 64'h0);

    // 6: reset with a read pending
    wr(5'h10, 32'h0007_0001);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 5'h00;
    #2 reset = 1'b1;
    @(negedge clk);
    check("t6_rsp_discarded", {63'd0, bus.rsp_valid}, 64'd0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd(5'h00, d); check("t6_mtime_lo", {32'd0, d}, 64'h0);
    rd(5'h04, d); check("t6_mtime_hi", {32'd0, d}, 64'h0);
    rd(5'h08, d); check("t6_cmp_lo", {32'd0, d}, 64'hFFFF_FFFF);
    rd(5'h0C, d); check("t6_cmp_hi", {32'd0, d}, 64'hFFFF_FFFF);
    rd(5'h10, d); check("t6_ctrl", {32'd0, d}, 64'h0);
    rd(5'h18, d); check("t6_unmapped_18", {32'd0, d}, 64'h0);
    check("t6_intr", {63'd0, intr_timer}, 64'd0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
